// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache line <-> memory burst adaptor.
package cacheline_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] burst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_beat_shifter.sv
// Line buffer organised as BEATS slots of BURST_WIDTH bits. Parallel load
// fills it from a cache line (write path); per-beat writes fill it from memory
// (read path); per-beat reads feed the memory write data.
module beat_shifter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = LINE_WIDTH / BURST_WIDTH,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   load_i,
  input  logic [LINE_WIDTH-1:0]  load_line_i,
  input  logic                   wr_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [BURST_WIDTH-1:0] wr_beat_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [BURST_WIDTH-1:0] rd_beat_o,
  output logic [LINE_WIDTH-1:0]  merged_o
);

  logic [BEATS-1:0][BURST_WIDTH-1:0] beats_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] merged;

  // Buffer contents: a whole-line load wins over a single-beat write.
  always_ff @(posedge clk) begin
    if (load_i) begin
      beats_q <= load_line_i;
    end else if (wr_i) begin
      beats_q[wr_idx_i] <= wr_beat_i;
    end
  end

  // Line as it will look once the beat being written this cycle lands, so the
  // final read beat can go straight to the output register.
  always_comb begin
    merged           = beats_q;
    merged[wr_idx_i] = wr_beat_i;
  end

  assign merged_o  = merged;
  assign rd_beat_o = beats_q[rd_idx_i];

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache line <-> 64-bit memory burst adaptor. One burst per line request,
// little-endian beat order, all outputs registered.
// Optional watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN to add timeout_o and
// abort a burst after TIMEOUT_CYCLES cycles without a memory response.
module cacheline_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  output logic                   timeout_o,
`endif
  input  logic                   resp_i
);

  import cacheline_pkg::*;

  localparam int NBEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NBEATS - 1);

  // Reject geometries the beat indexing cannot represent.
  if ((NBEATS < 1) || ((NBEATS & (NBEATS - 1)) != 0) ||
      (NBEATS * BURST_WIDTH != LINE_WIDTH)) begin : g_bad_geometry
    $error("cacheline_adaptor: LINE_WIDTH/BURST_WIDTH must be a power of two");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cacheline_adaptor: TIMEOUT_CYCLES must be at least 1");
  end

  adaptor_state_t          state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [BURST_WIDTH-1:0]  burst_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    read_q;
  logic                    write_q;
  logic                    resp_q;

  logic                    buf_load;
  logic                    buf_wr;
  logic [CNT_W-1:0]        next_idx;
  logic [BURST_WIDTH-1:0]  next_beat;
  logic [LINE_WIDTH-1:0]   merged_line;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             timeout_q;
`endif

  // Buffer controls: load the write line on acceptance, capture beats while reading.
  always_comb begin
    buf_load = (state_q == IDLE) && write_i;
    buf_wr   = (state_q == READ) && resp_i;
    next_idx = cnt_q + CNT_W'(1);
  end

  beat_shifter #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH),
    .BEATS       (NBEATS),
    .IDX_W       (CNT_W)
  ) u_beat_shifter (
    .clk         (clk),
    .load_i      (buf_load),
    .load_line_i (line_i),
    .wr_i        (buf_wr),
    .wr_idx_i    (cnt_q),
    .wr_beat_i   (burst_i),
    .rd_idx_i    (next_idx),
    .rd_beat_o   (next_beat),
    .merged_o    (merged_line)
  );

  // Request FSM with all cache- and memory-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      line_q    <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      resp_q    <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          tmo_q <= '0;
`endif
          if (write_i) begin
            // Write wins when both requests arrive together.
            state_q <= WRITE;
            addr_q  <= address_i & ALIGN_MASK;
            write_q <= 1'b1;
            burst_q <= line_i[BURST_WIDTH-1:0];
          end else if (read_i) begin
            state_q <= READ;
            addr_q  <= address_i & ALIGN_MASK;
            read_q  <= 1'b1;
          end
        end
        READ: begin
          if (resp_i) begin
            cnt_q <= next_idx;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (cnt_q == LAST_BEAT) begin
              state_q <= DONE;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              line_q  <= merged_line;
            end
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          else if (tmo_q == TMO_LIMIT) begin
            state_q   <= DONE;
            read_q    <= 1'b0;
            resp_q    <= 1'b1;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        WRITE: begin
          if (resp_i) begin
            cnt_q <= next_idx;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (cnt_q == LAST_BEAT) begin
              state_q <= DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              burst_q <= '0;
            end else begin
              burst_q <= next_beat;
            end
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          else if (tmo_q == TMO_LIMIT) begin
            state_q   <= DONE;
            write_q   <= 1'b0;
            resp_q    <= 1'b1;
            timeout_q <= 1'b1;
            burst_q   <= '0;
            cnt_q     <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and randomized line
// reads/writes against a transaction-level model of the expected outputs.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic         timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [255:0] model_line;   // what line_o must currently hold
  logic [63:0]  rbeats [4];   // beats memory returns for the next read
  bit           pat_q [$];    // resp_i pattern; 1 once exhausted

  cacheline_adaptor #(
    .LINE_WIDTH     (256),
    .BURST_WIDTH    (64),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    .timeout_o (timeout_o),
`endif
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One line read: accept, feed 4 beats following pat_q, check every cycle.
  task automatic do_read(input logic [31:0] addr);
    logic [255:0] exp_line;
    int idx;
    int cyc;
    bit r;
    for (int i = 0; i < 4; i++) exp_line[64*i +: 64] = rbeats[i];
    address_i = addr; read_i = 1'b1; write_i = 1'b0;
    tick();
    read_i = 1'b0;
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0 || address_o !== (addr & 32'hFFFF_FFE0)) begin
      errors++;
      $display("FAIL rd_accept read_o=%b write_o=%b addr_o=%h exp 1 0 %h", read_o, write_o, address_o, addr & 32'hFFFF_FFE0);
    end
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 64) begin
      r = (pat_q.size() != 0) ? pat_q.pop_front() : 1'b1;
      resp_i  = r;
      burst_i = r ? rbeats[idx] : rnd64();
      tick();
      resp_i = 1'b0;
      if (r) idx++;
      cyc++;
      checks++;
      if (idx < 4) begin
        if (resp_o !== 1'b0 || read_o !== 1'b1) begin
          errors++;
          $display("FAIL rd_beat%0d resp_o=%b read_o=%b exp 0 1", idx, resp_o, read_o);
        end
      end else begin
        model_line = exp_line;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== model_line) begin
          errors++;
          $display("FAIL rd_done resp_o=%b read_o=%b line_o=%h exp 1 0 %h", resp_o, read_o, line_o, model_line);
        end
      end
    end
    if (idx < 4) begin
      errors++;
      $display("FAIL rd_bound beats=%0d exp 4", idx);
    end
    tick();
    checks++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse resp_o=%b read_o=%b exp 0 0", resp_o, read_o);
    end
  endtask

  // One line write; also_read drives read_i alongside write_i.
  task automatic do_write(input logic [255:0] line, input logic [31:0] addr, input bit also_read);
    int idx;
    int cyc;
    bit r;
    line_i = line; address_i = addr; write_i = 1'b1; read_i = also_read;
    tick();
    write_i = 1'b0; read_i = 1'b0;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== line[63:0] ||
        address_o !== (addr & 32'hFFFF_FFE0)) begin
      errors++;
      $display("FAIL wr_accept write_o=%b read_o=%b burst_o=%h exp 1 0 %h", write_o, read_o, burst_o, line[63:0]);
    end
    line_i = {rnd64(), rnd64(), rnd64(), rnd64()};
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 64) begin
      r = (pat_q.size() != 0) ? pat_q.pop_front() : 1'b1;
      resp_i  = r;
      burst_i = rnd64();
      tick();
      resp_i = 1'b0;
      if (r) idx++;
      cyc++;
      checks++;
      if (idx < 4) begin
        if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== line[64*idx +: 64]) begin
          errors++;
          $display("FAIL wr_beat%0d write_o=%b read_o=%b resp_o=%b burst_o=%h exp 1 0 0 %h",
                   idx, write_o, read_o, resp_o, burst_o, line[64*idx +: 64]);
        end
      end else begin
        if (write_o !== 1'b0 || read_o !== 1'b0 || resp_o !== 1'b1 || line_o !== model_line) begin
          errors++;
          $display("FAIL wr_done write_o=%b resp_o=%b line_o=%h exp 0 1 %h", write_o, resp_o, line_o, model_line);
        end
      end
    end
    if (idx < 4) begin
      errors++;
      $display("FAIL wr_bound beats=%0d exp 4", idx);
    end
    tick();
    checks++;
    if (resp_o !== 1'b0 || write_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse resp_o=%b write_o=%b exp 0 0", resp_o, write_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    tick(); tick();
    rst = 1'b0;
    model_line = '0;
    checks++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0 || read_o !== 0 || write_o !== 0 || resp_o !== 0) begin
      errors++;
      $display("FAIL reset line_o=%h burst_o=%h addr_o=%h rd=%b wr=%b resp=%b exp all 0",
               line_o, burst_o, address_o, read_o, write_o, resp_o);
    end
    // resp_i is ignored while idle
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = rnd64();
      tick();
      checks++;
      if (read_o !== 0 || write_o !== 0 || resp_o !== 0 || line_o !== model_line) begin
        errors++;
        $display("FAIL idle_resp rd=%b wr=%b resp=%b exp 0 0 0", read_o, write_o, resp_o);
      end
    end
    resp_i = 1'b0;
  endtask

  task automatic test_read_b2b();
    rbeats[0] = {16{4'h1}}; rbeats[1] = {16{4'h2}};
    rbeats[2] = {16{4'h3}}; rbeats[3] = {16{4'h4}};
    pat_q.delete();
    do_read(32'h0000_1234);
    checks++;
    if (line_o !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) begin
      errors++;
      $display("FAIL rd_b2b_line line_o=%h", line_o);
    end
  endtask

  task automatic test_write();
    pat_q.delete();
    do_write(256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 32'h0000_ABCD, 1'b0);
  endtask

  task automatic test_read_gaps();
    for (int i = 0; i < 4; i++) rbeats[i] = rnd64();
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    do_read(32'h8000_003F);
  endtask

  task automatic test_simultaneous();
    pat_q.delete();
    do_write({rnd64(), rnd64(), rnd64(), rnd64()}, 32'h0000_0040, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 4; i++) rbeats[i] = rnd64();
    address_i = 32'h0000_2000; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = rbeats[i];
      tick();
    end
    rst = 1'b1; resp_i = 1'b1; burst_i = rbeats[2];
    tick();
    rst = 1'b0; resp_i = 1'b0;
    model_line = '0;
    checks++;
    if (read_o !== 0 || line_o !== '0 || resp_o !== 0 || write_o !== 0) begin
      errors++;
      $display("FAIL rst_mid rd=%b line_o=%h resp=%b exp 0 0 0", read_o, line_o, resp_o);
    end
    tick();
    checks++;
    if (resp_o !== 0 || read_o !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle resp=%b rd=%b exp 0 0", resp_o, read_o);
    end
    for (int i = 0; i < 4; i++) rbeats[i] = rnd64();
    pat_q.delete();
    do_read(32'h0000_2010);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      pat_q.delete();
      for (int k = 0; k < int'($urandom_range(0, 8)); k++) pat_q.push_back(bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) rbeats[i] = rnd64();
        do_read($urandom);
      end else begin
        do_write({rnd64(), rnd64(), rnd64(), rnd64()}, $urandom, bit'($urandom_range(0, 1)));
      end
    end
  endtask

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  task automatic test_timeout();
    address_i = 32'h0000_0100; read_i = 1'b1; resp_i = 1'b0;
    tick();
    read_i = 1'b0;
    for (int c = 1; c < 17; c++) begin
      checks++;
      if (resp_o !== 0 || timeout_o !== 0) begin
        errors++;
        $display("FAIL tmo_wait cycle=%0d resp=%b timeout=%b exp 0 0", c, resp_o, timeout_o);
      end
      tick();
    end
    checks++;
    if (resp_o !== 1 || timeout_o !== 1 || read_o !== 0 || line_o !== model_line) begin
      errors++;
      $display("FAIL tmo_fire resp=%b timeout=%b rd=%b exp 1 1 0", resp_o, timeout_o, read_o);
    end
    tick(); tick();
    checks++;
    if (resp_o !== 0 || timeout_o !== 1) begin
      errors++;
      $display("FAIL tmo_sticky resp=%b timeout=%b exp 0 1", resp_o, timeout_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    model_line = '0;
    test_reset();
    test_read_b2b();
    test_write();
    test_read_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Bridges the cache's single-cycle line interface to the physical memory's 64-bit burst interface.
- On a read, it issues one burst read, deserializes the returned beats into a line, then responds to the cache.
- On a write, it latches the line, serializes it into beats, then responds.
- Sits between the L1 cache/arbiter and main memory.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (must divide evenly, power of two).
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- line_i  input  LINE_WIDTH  write data from the cache.
- line_o  output  LINE_WIDTH  read data to the cache.
- address_i  input  ADDR_WIDTH  cache request byte address.
- read_i  input  1  cache read request.
- write_i  input  1  cache write request.
- resp_o  output  1  one-cycle completion pulse to the cache.
- burst_i  input  BURST_WIDTH  memory read beat.
- burst_o  output  BURST_WIDTH  memory write beat.
- address_o  output  ADDR_WIDTH  line-aligned memory address.
- read_o  output  1  memory read request.
- write_o  output  1  memory write request.
- resp_i  input  1  memory beat valid/accepted.

Behaviour:
- Reset: FSM to IDLE. line_o, burst_o, address_o, read_o, write_o, resp_o all 0. Beat counter 0.
- All outputs are registered; no combinational path from any input to any output.
- Address alignment: address_o = address_i with the low log2(LINE_WIDTH/8) bits (5 by default) cleared. Latched when a request is accepted; held until DONE.

FSM states and transitions:
- IDLE
  - write_i=1: latch line_i and address; go to WRITE. Write has priority if read_i and write_i are both high.
  - Else read_i=1: latch address; go to READ.
  - resp_i in IDLE is ignored.
- READ
  - read_o=1 held.
  - Each cycle with resp_i=1: store burst_i into beat slot [cnt] (beat 0 = bits BURST_WIDTH-1:0, little-endian beat order); cnt++.
  - resp_i gaps are tolerated: no capture, no advance.
  - After beat BEATS-1 is captured: read_o drops the next cycle; go to DONE.
- WRITE
  - write_o=1 held; burst_o = latched beat [cnt].
  - Each cycle with resp_i=1: current beat is accepted; cnt++; burst_o shows the next beat the following cycle.
  - After beat BEATS-1 is accepted: go to DONE.
- DONE
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - line_o holds the assembled line; it is updated only on read completion and keeps its last value otherwise.
  - Then go to IDLE.
- Cache requests are sampled only in IDLE. read_i/write_i held through DONE are not re-accepted: the cache must deassert them in the cycle after resp_o.
  - Latency: the earliest new acceptance is the cycle after returning to IDLE.
- Minimum read latency: request accepted at cycle 0, beats at cycles 1..4, resp_o at cycle 5.
- Reset mid-operation: abort immediately to IDLE. Partial line is discarded; line_o is cleared to 0.
- Counter width: log2(BEATS); it wraps to 0 on entry to DONE.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit, reset 0).
  - A cycle counter runs in READ/WRITE and resets on every resp_i.
  - If it reaches TIMEOUT_CYCLES: abort to DONE. resp_o pulses, timeout_o=1 in the same cycle, line_o is unchanged on a read.
  - timeout_o stays sticky until rst.
- Not defined: no port, no counter; the adaptor waits indefinitely.

Decomposition:
- Shared package cacheline_pkg holds:
  - LINE_WIDTH, BURST_WIDTH, BEATS constants;
  - typedefs line_t, burst_t;
  - enum adaptor_state_t {IDLE, READ, WRITE, DONE}.
- One natural sub-module: beat_shifter, holding the line buffer. It supports parallel load, per-beat write at an index, and per-beat read at an index; it is shared by the read and write paths.

Test Plan:
- Read, back-to-back beats: address_i=0x0000_1234, read_i. Memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 at cycles 1-4.
  - Required: address_o=0x0000_1220; resp_o at cycle 5; line_o={0x44..,0x33..,0x22..,0x11..}.
- Write: line_i=256'h0123...CDEF, write_i, resp_i high 4 cycles.
  - Required: burst_o sequence = line bits [63:0],[127:64],[191:128],[255:192]; write_o low after beat 4; one resp_o pulse.
- Read with gaps: resp_i pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 beats captured in order; resp_o one cycle after the last beat.
- Simultaneous read_i=write_i=1 in IDLE.
  - Required: write_o asserted; read_o stays 0.
- rst asserted after beat 2 of a read.
  - Required: next cycle IDLE, read_o=0, line_o=0, no resp_o. A new read then completes normally.
- With CACHELINE_ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16: read, resp_i never asserted.
  - Required: resp_o and timeout_o at cycle 17; timeout_o stays 1.
